// File: rtl/fft_pkg.sv
// Shared parameters, state type and fftpts encoding for the FFT frame transmitter.
package fft_pkg;

  localparam int FFT_DATA_W     = 24;
  localparam int FFT_LEN        = 256;
  localparam int FFT_FIFO_DEPTH = 512;

  typedef enum logic {IDLE, SEND} tx_state_t;

  // The FFT core takes the point count as a plain binary number.
  function automatic int unsigned fftpts_enc(input int unsigned len);
    return len;
  endfunction

endpackage

// File: rtl/fft_frame_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; head and the word behind it are both visible.
module sync_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [DATA_W-1:0]        head_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q, rd_ptr_inc;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  assign head       = mem_q[rd_ptr_q];
  assign head_next  = mem_q[rd_ptr_inc];
  assign count      = count_q;
  assign count_next = count_d;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_inc;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fft_frame_tx.sv
// Frames buffered synth samples into fixed-length Avalon-ST packets for the FFT sink.
// state | meaning:  IDLE | waiting for a full frame in the FIFO;  SEND | streaming a frame
module fft_frame_tx
  import fft_pkg::*;
#(
  parameter int DATA_W     = FFT_DATA_W,
  parameter int FRAME_LEN  = FFT_LEN,
  parameter int FIFO_DEPTH = FFT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_valid,
  input  logic [DATA_W-1:0]           sample,
  input  logic                        src_ready,
  output logic                        src_valid,
  output logic                        src_sop,
  output logic                        src_eop,
  output logic [DATA_W-1:0]           src_real,
  output logic [DATA_W-1:0]           src_imag,
  output logic [1:0]                  src_error,
  output logic [$clog2(FRAME_LEN):0]  src_fftpts,
  output logic                        overflow,
  output logic [15:0]                 frame_count
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LEN_C    = CW'(FRAME_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] IDX_PRE  = IW'(FRAME_LEN - 2);

  tx_state_t         state_q;
  logic [IW-1:0]     idx_q;
  logic              valid_q, sop_q, eop_q, ovf_q;
  logic [DATA_W-1:0] real_q;
  logic [15:0]       fc_q;
  logic              beat;

  logic [DATA_W-1:0] fifo_head, fifo_head_next;
  logic [CW-1:0]     fifo_count, fifo_count_next;
  logic              fifo_full, fifo_empty;

  assign beat = valid_q && src_ready;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (sample_valid),
    .wr_data    (sample),
    .pop        (beat),
    .head       (fifo_head),
    .head_next  (fifo_head_next),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A whole frame is buffered before SOP, so head_next is always valid data on a beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      ovf_q   <= 1'b0;
      real_q  <= '0;
      fc_q    <= '0;
    end else begin
      if (sample_valid && fifo_full) ovf_q <= 1'b1;
      if (beat && eop_q) fc_q <= fc_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (!fifo_empty && fifo_count >= LEN_C) begin
            state_q <= SEND;
            idx_q   <= '0;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            real_q  <= fifo_head;
          end
        end
        SEND: begin
          if (beat) begin
            if (idx_q == IDX_LAST) begin
              if (fifo_count_next >= LEN_C) begin
                idx_q  <= '0;
                sop_q  <= 1'b1;
                eop_q  <= 1'b0;
                real_q <= fifo_head_next;
              end else begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
              end
            end else begin
              idx_q  <= idx_q + 1'b1;
              sop_q  <= 1'b0;
              eop_q  <= (idx_q == IDX_PRE);
              real_q <= fifo_head_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_valid   = valid_q;
  assign src_sop     = sop_q;
  assign src_eop     = eop_q;
  assign src_real    = real_q;
  assign src_imag    = '0;
  assign src_error   = 2'b00;
  assign src_fftpts  = (IW + 1)'(fftpts_enc(FRAME_LEN));
  assign overflow    = ovf_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Self-checking bench for fft_frame_tx: queue-based reference model plus table and directed cases.
`timescale 1ns/1ps
module tb_fft_frame_tx;

  localparam int DW    = 24;
  localparam int LEN   = 256;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          src_ready = 1'b0;
  logic          src_valid, src_sop, src_eop, overflow;
  logic [DW-1:0] src_real, src_imag;
  logic [1:0]    src_error;
  logic [8:0]    src_fftpts;
  logic [15:0]   frame_count;

  fft_frame_tx #(.DATA_W(DW), .FRAME_LEN(LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .src_ready    (src_ready),
    .src_valid    (src_valid),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_real     (src_real),
    .src_imag     (src_imag),
    .src_error    (src_error),
    .src_fftpts   (src_fftpts),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired at %0t", name, $time);
  endtask

  // Reference model: accepted samples in a queue, frame position as a plain counter.
  logic [DW-1:0] mq[$];
  bit            m_ev;
  int            m_pt;
  bit            m_ovf;
  logic [15:0]   m_fc;

  task automatic model_step();
    int occ       = mq.size();
    bit beat      = m_ev && src_ready;
    bit eop_beat  = beat && (m_pt == LEN - 1);
    if (beat) begin
      void'(mq.pop_front());
      m_pt++;
      if (eop_beat) m_fc++;
    end
    if (sample_valid) begin
      if (occ >= DEPTH) m_ovf = 1'b1;
      else mq.push_back(sample);
    end
    if (!m_ev) begin
      if (occ >= LEN) begin
        m_ev = 1'b1;
        m_pt = 0;
      end
    end else if (eop_beat) begin
      m_pt = 0;
      if (mq.size() < LEN) m_ev = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ev = 1'b0; m_pt = 0; m_ovf = 1'b0; m_fc = '0;
      chk("rst_valid", src_valid, 0);
      chk("rst_sop", src_sop, 0);
      chk("rst_eop", src_eop, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fc", frame_count, 0);
    end else begin
      chk("valid", src_valid, m_ev);
      if (m_ev) begin
        chk("sop", src_sop, m_pt == 0);
        chk("eop", src_eop, m_pt == LEN - 1);
        chk("data", src_real, mq[0]);
      end
      chk("frame_count", frame_count, m_fc);
      chk("overflow", overflow, m_ovf);
      model_step();
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; sample_valid = 1'b0; src_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic push_seq(input int n, input int base, input int data_mode, input int rdy_mode);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample = (data_mode == 0) ? DW'(base + i) : DW'($urandom);
      if (rdy_mode == 2) src_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int rdy_mode);
    for (int c = 0; c < 4000; c++) begin
      src_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      if (!m_ev && mq.size() < LEN) return;
    end
    fail_bound("drain");
  endtask

  task automatic wait_data(input string name, input int value, output bit found);
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (src_valid && src_real == DW'(value)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) fail_bound(name);
  endtask

  typedef struct {
    int n_push;
    int rdy_mode;   // 0 ready throughout, 1 stalled while filling, 2 random
    int data_mode;  // 0 incrementing from 0, 1 random
    int exp_fc;
    bit exp_ovf;
  } vec_t;

  initial begin
    vec_t tbl[6];
    bit   found;
    int   gap;
    tbl[0] = '{256, 0, 0, 1, 1'b0};
    tbl[1] = '{512, 1, 0, 2, 1'b0};
    tbl[2] = '{513, 1, 0, 2, 1'b1};
    tbl[3] = '{300, 2, 1, 1, 1'b0};
    tbl[4] = '{700, 0, 1, 2, 1'b0};
    tbl[5] = '{600, 2, 1, 2, 1'b0};

    do_reset();
    chk("fftpts", src_fftpts, 256);
    chk("imag", src_imag, 0);
    chk("error", src_error, 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      src_ready = (tbl[t].rdy_mode == 0);
      push_seq(tbl[t].n_push, 0, tbl[t].data_mode, tbl[t].rdy_mode);
      drain(tbl[t].rdy_mode);
      chk($sformatf("tbl%0d_frame_count", t), frame_count, tbl[t].exp_fc);
      chk($sformatf("tbl%0d_overflow", t), overflow, tbl[t].exp_ovf);
      chk($sformatf("tbl%0d_idle", t), src_valid, 0);
    end

    // Backpressure at point 100.
    do_reset();
    src_ready = 1'b1;
    push_seq(256, 0, 0, 0);
    wait_data("stall_find", 100, found);
    if (found) begin
      src_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("stall_data", src_real, 100);
        chk("stall_valid", src_valid, 1);
      end
    end
    drain(0);
    chk("stall_frame_count", frame_count, 1);

    // Overflow on sample 513, then asynchronous reset mid-frame.
    do_reset();
    push_seq(512, 0, 0, 1);
    chk("ovf_before", overflow, 0);
    push_seq(1, 512, 0, 1);
    chk("ovf_after", overflow, 1);
    src_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("pre_rst_fc", frame_count, 1);
    chk("pre_rst_valid", src_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", src_valid, 0);
    chk("async_ovf", overflow, 0);
    chk("async_fc", frame_count, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back frames: next SOP exactly LEN cycles after the first.
    do_reset();
    push_seq(512, 0, 0, 1);
    src_ready = 1'b1;
    gap = 0;
    for (int c = 1; c <= 300 && gap == 0; c++) begin
      @(posedge clk); #1;
      if (src_valid && src_sop) gap = c;
    end
    chk("b2b_gap", gap, 256);
    drain(0);
    chk("b2b_frame_count", frame_count, 2);

    // Reset at point 50, then a clean frame of new samples.
    do_reset();
    src_ready = 1'b1;
    push_seq(256, 0, 0, 0);
    wait_data("rst50_find", 50, found);
    reset_n = 1'b0;
    #1 chk("rst50_valid", src_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_seq(256, 1000, 0, 0);
    wait_data("rst50_sop_find", 1000, found);
    if (found) chk("rst50_sop", src_sop, 1);
    drain(0);
    chk("rst50_frame_count", frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
